// File: rtl/iiitb_alu_if.sv
// Operand/opcode/result bundle for the registered 8-bit ALU.
// The master drives operands and opcode; the slave (the ALU) drives the result.
interface iiitb_alu_if;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] op;
  logic [7:0] R;

  modport master (output A, output B, output op, input R);
  modport slave  (input A, input B, input op, output R);
endinterface

// File: rtl/iiitb_alu.sv
// 8-bit ALU: a combinational opcode decode feeding one result register.
// R only ever comes from the register, so there is no input-to-output path.
module iiitb_alu (
  input logic        clk,
  input logic        rst_n,
  iiitb_alu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  logic [7:0] res;

  // An 8-bit context keeps only the low byte, which covers the ADD/SUB wrap
  // and the truncated MUL product.
  always_comb begin
    res = 8'h00;
    case (alu_op_e'(bus.op))
      OP_ADD:  res = bus.A + bus.B;
      OP_SUB:  res = bus.A - bus.B;
      OP_MUL:  res = bus.A * bus.B;
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_XOR:  res = bus.A ^ bus.B;
      OP_SHL:  res = {bus.A[6:0], 1'b0};
      OP_SHR:  res = {1'b0, bus.A[7:1]};
      default: res = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.R <= 8'h00;
    else        bus.R <= res;
  end

endmodule

// File: tb/tb_iiitb_alu.sv
// Directed-vector bench for iiitb_alu; the expected results are worked out by hand.
module tb_iiitb_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  iiitb_alu_if bus ();

  iiitb_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: R=%02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive the inputs at the negative edge, let the next rising edge capture
  // them, then sample 1 time unit after that edge.
  task automatic step(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.op = o; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    chk(tag, bus.R, exp);
  endtask

  logic [7:0] sweep [8] = '{8'hA5, 8'h2F, 8'h6E, 8'h2A, 8'h7B, 8'h51, 8'hD4, 8'h35};

  initial begin
    bus.A = 8'hFF; bus.B = 8'hFF; bus.op = 3'd0;
    #1 chk("reset_async", bus.R, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", bus.R, 8'h00);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_release_add", bus.R, 8'hFE);

    for (int i = 0; i < 8; i++) step(3'(i), 8'h6A, 8'h3B, sweep[i], $sformatf("sweep_op%0d", i));

    step(3'd0, 8'hFF, 8'h01, 8'h00, "wrap_add");
    step(3'd1, 8'h00, 8'h01, 8'hFF, "wrap_sub");
    step(3'd2, 8'h10, 8'h10, 8'h00, "wrap_mul_10");
    step(3'd2, 8'hFF, 8'hFF, 8'h01, "wrap_mul_ff");

    step(3'd6, 8'h81, 8'h00, 8'h02, "shl");
    step(3'd6, 8'h81, 8'hFF, 8'h02, "shl_b_ignored");
    step(3'd7, 8'h81, 8'h00, 8'h40, "shr");
    step(3'd7, 8'h81, 8'h5A, 8'h40, "shr_b_ignored");

    // Inputs wander between edges but are restored before the capturing edge.
    @(negedge clk);
    bus.op = 3'd3; bus.A = 8'h00; bus.B = 8'h00;
    #2 bus.op = 3'd2; bus.A = 8'hFF;
    #1 chk("glitch_no_early_change", bus.R, 8'h40);
    bus.op = 3'd0; bus.A = 8'h6A; bus.B = 8'h3B;
    @(posedge clk); #1;
    chk("glitch_edge_value", bus.R, 8'hA5);

    // Pulse reset low between edges while R holds A5.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 chk("midrun_async_reset", bus.R, 8'h00);
    #1 rst_n = 1'b1;
    #1 chk("midrun_before_edge", bus.R, 8'h00);
    @(posedge clk); #1;
    chk("midrun_reload", bus.R, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/iiitb_alu.md
Name: iiitb_alu

Overview:
- 8-bit registered arithmetic/logic unit.
- Computes one of eight operations on operands A and B, selected by a 3-bit opcode.
- The result is captured in an output register on the rising clock edge.
- Used as a leaf datapath block; it has no handshake and accepts a new operation every cycle.

Parameters:
- None. Data width is fixed at 8 bits and the opcode at 3 bits.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- op  input  3  operation select.
- R  output  8  registered result.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low forces R = 8'h00 immediately, without waiting for a clock edge.
  - R is held at 8'h00 while rst_n is low.
- Normal operation:
  - On each rising clk edge with rst_n high, R <= f(op, A, B).
  - A, B and op are sampled at that edge.
- Latency and throughput:
  - Latency is 1 cycle; the result is visible after the edge that sampled its inputs.
  - Throughput is one operation per cycle.
  - Input changes between edges do not affect R.
- Opcode map (all results truncated to 8 bits, unsigned, no flags):
  - 0 ADD: (A + B) mod 256; the carry is discarded.
  - 1 SUB: (A - B) mod 256; two's-complement wrap.
  - 2 MUL: low 8 bits of the 16-bit product A * B.
  - 3 AND: A & B.
  - 4 OR: A | B.
  - 5 XOR: A ^ B.
  - 6 SHL: A << 1; bit 0 is filled with 0 and A[7] is discarded. B is ignored.
  - 7 SHR: A >> 1 (logical); bit 7 is filled with 0 and A[0] is discarded. B is ignored.
- Boundary conditions:
  - The full 3-bit opcode space is decoded, so there is no illegal opcode.
  - Any op value containing X/Z in simulation is not a supported input; RTL drives a default of 8'h00 in the case default.
  - Overflow and underflow wrap silently.
- Reset timing:
  - Reset asserted mid-stream discards the pending result.
  - The first rising edge after rst_n deasserts loads the result for the inputs present at that edge.
  - rst_n deasserting coincident with a clk edge is a sampled-at-edge race; the bench avoids it.
- Implementation constraints:
  - R is a pure register output, with no combinational path from the inputs to R.
  - The result logic is purely combinational, with a single 8-bit register stage.

Test Plan:
- Reset: drive rst_n = 0 with A=8'hFF, B=8'hFF, op=0 and toggle clk -> R = 8'h00 throughout; release rst_n, next edge -> R = 8'hFE.
- Opcode sweep: A=8'h6A, B=8'h3B, step op 0..7, one per clock edge -> R after each edge = A5, 2F, 6E, 2A, 7B, 51, D4, 35.
- Wrap:
  - op=0, A=8'hFF, B=8'h01 -> R = 8'h00.
  - op=1, A=8'h00, B=8'h01 -> R = 8'hFF.
  - op=2, A=8'h10, B=8'h10 -> R = 8'h00.
  - op=2, A=8'hFF, B=8'hFF -> R = 8'h01.
- Shifts: op=6, A=8'h81 -> R = 8'h02; op=7, A=8'h81 -> R = 8'h40. Changing B causes no change in R.
- Mid-cycle glitch: change op/A/B between edges, then restore before the edge -> R reflects only the values present at the edge.
- Async reset mid-operation: pulse rst_n low between edges while R = 8'hA5 -> R drops to 8'h00 before the next edge and reloads on the first edge after release.
